// File: rtl/iddmm_addsub_serial.sv
// Word-serial multi-word adder/subtractor, least-significant word first.
// One word pair per cycle with a registered result word one cycle later.
module iddmm_addsub_serial #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] cfg_words,
  input  logic              cfg_sub,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_a,
  input  logic [K-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_flag,
  output logic              out_zero
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_mode;
  logic                r_cb;
  logic                r_zeroAcc;
  logic [ADDR_W-1:0]   w_cfgLen;
  logic [ADDR_W-1:0]   w_len;
  logic [ADDR_W-1:0]   w_cnt;
  logic                w_mode;
  logic                w_cin;
  logic                w_fire;
  logic                w_lastWord;
  logic                w_cout;
  logic                w_zero;
  logic [K:0]          w_sum;
  logic [K-1:0]        w_res;

  // Saturation is only needed when N is not a power of two.
  generate
    if (N < (1 << ADDR_W)) begin : g_sat
      assign w_cfgLen = (cfg_words > ADDR_W'(N - 1)) ? ADDR_W'(N - 1) : cfg_words;
    end else begin : g_nosat
      assign w_cfgLen = cfg_words;
    end
  endgenerate

  assign in_ready = (!out_valid || out_ready) && !clear && !rst;
  assign w_fire   = in_valid && in_ready;

  // In IDLE the incoming word is word 0: take config from the ports and start with no carry.
  always_comb begin
    w_len  = r_len;
    w_mode = r_mode;
    w_cnt  = r_cnt;
    w_cin  = r_cb;
    if (r_state == IDLE) begin
      w_len  = w_cfgLen;
      w_mode = cfg_sub;
      w_cnt  = '0;
      w_cin  = 1'b0;
    end
    // Bit K of the (K+1)-bit result is the carry in add mode and the borrow in sub mode.
    if (w_mode)
      w_sum = {1'b0, in_a} - {1'b0, in_b} - {{K{1'b0}}, w_cin};
    else
      w_sum = {1'b0, in_a} + {1'b0, in_b} + {{K{1'b0}}, w_cin};
    w_res      = w_sum[K-1:0];
    w_cout     = w_sum[K];
    w_lastWord = (w_cnt == w_len);
    w_zero     = (w_res == '0) && ((r_state == IDLE) || r_zeroAcc);
  end

  always_comb begin
    w_stateNext = r_state;
    if (clear)
      w_stateNext = IDLE;
    else if (w_fire)
      w_stateNext = w_lastWord ? IDLE : BUSY;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_mode    <= 1'b0;
      r_cnt     <= '0;
      r_cb      <= 1'b0;
      r_zeroAcc <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      out_flag  <= 1'b0;
      out_zero  <= 1'b0;
    end else if (clear) begin
      r_cnt     <= '0;
      r_cb      <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_fire) begin
      r_len     <= w_len;
      r_mode    <= w_mode;
      r_cnt     <= w_lastWord ? '0 : w_cnt + 1'b1;
      r_cb      <= w_lastWord ? 1'b0 : w_cout;
      r_zeroAcc <= w_zero;
      out_valid <= 1'b1;
      out_data  <= w_res;
      out_addr  <= w_cnt;
      out_last  <= w_lastWord;
      out_flag  <= w_lastWord && w_cout;
      out_zero  <= w_lastWord && w_zero;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iddmm_addsub_serial.sv
// Scoreboard bench for iddmm_addsub_serial at K=8, N=4 using directed vectors.
module tb_iddmm_addsub_serial;

  localparam int K = 8;
  localparam int N = 4;
  localparam int ADDR_W = 2;

  typedef struct {
    logic [K-1:0]      data;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              flag;
    logic              zero;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              clear;
  logic [ADDR_W-1:0] cfg_words;
  logic              cfg_sub;
  logic              in_valid;
  logic              in_ready;
  logic [K-1:0]      in_a;
  logic [K-1:0]      in_b;
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              out_flag;
  logic              out_zero;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cycleCount = 0;
  logic        holdSeen = 1'b0;
  logic [K-1:0] holdData;
  int          c1;
  int          c2;

  iddmm_addsub_serial #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_words(cfg_words), .cfg_sub(cfg_sub),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .out_flag(out_flag), .out_zero(out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Presents one word pair, waits for acceptance, then records the expected result word.
  task automatic applyStimulus(input logic [K-1:0] a, input logic [K-1:0] b,
                               input logic [ADDR_W-1:0] words, input logic sub,
                               input logic [K-1:0] eData, input logic [ADDR_W-1:0] eAddr,
                               input logic eLast, input logic eFlag, input logic eZero,
                               output int fireCyc);
    int budget;
    exp_t e;
    in_a = a;
    in_b = b;
    cfg_words = words;
    cfg_sub = sub;
    in_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      fireCyc = -1;
    end else begin
      @(posedge clk);
      #1;
      fireCyc = cycleCount;
      in_valid = 1'b0;
      e.data = eData;
      e.addr = eAddr;
      e.last = eLast;
      e.flag = eFlag;
      e.zero = eZero;
      sb.push_back(e);
      checkOutput("latencyValid", 32'(out_valid), 32'd1);
      checkOutput("latencyAddr", 32'(out_addr), 32'(eAddr));
    end
  endtask

  // Aborts with clear or rst while word 2 is presented; nothing may be accepted.
  task automatic abortOp(input logic useRst);
    in_a = 8'h55;
    in_b = 8'h11;
    in_valid = 1'b1;
    if (useRst) rst = 1'b1;
    else clear = 1'b1;
    @(negedge clk);
    checkOutput("abortInReady", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    checkOutput("abortValidDrop", 32'(out_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b0) begin
      checkOutput("stallInReady", 32'(in_ready), 32'd0);
      if (holdSeen) checkOutput("stallDataStable", 32'(out_data), 32'(holdData));
      holdSeen = 1'b1;
      holdData = out_data;
    end else begin
      holdSeen = 1'b0;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedWord", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        checkOutput("data", 32'(out_data), 32'(e.data));
        checkOutput("addr", 32'(out_addr), 32'(e.addr));
        checkOutput("last", 32'(out_last), 32'(e.last));
        if (e.last) begin
          checkOutput("flag", 32'(out_flag), 32'(e.flag));
          checkOutput("zero", 32'(out_zero), 32'(e.zero));
        end
      end
    end
  end

  initial begin
    int fc;
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    cfg_words = '0;
    cfg_sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstData", 32'(out_data), 32'd0);
    checkOutput("rstAddr", 32'(out_addr), 32'd0);
    checkOutput("rstFlags", {29'd0, out_last, out_flag, out_zero}, 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("inReadyAfterRst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] add with carry chain");
    applyStimulus(8'hFF, 8'h01, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, fc);
    applyStimulus(8'h01, 8'h00, 2'd1, 1'b0, 8'h02, 2'd1, 1'b1, 1'b0, 1'b0, fc);

    $display("[TB] subtract with borrow out");
    applyStimulus(8'h00, 8'h01, 2'd1, 1'b1, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, fc);
    applyStimulus(8'h00, 8'h00, 2'd1, 1'b1, 8'hFF, 2'd1, 1'b1, 1'b1, 1'b0, fc);

    $display("[TB] equal operands");
    applyStimulus(8'h78, 8'h78, 2'd3, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, fc);
    applyStimulus(8'h56, 8'h56, 2'd0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, fc);
    applyStimulus(8'h34, 8'h34, 2'd0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, fc);
    applyStimulus(8'h12, 8'h12, 2'd0, 1'b0, 8'h00, 2'd3, 1'b1, 1'b0, 1'b1, fc);

    $display("[TB] backpressure");
    fork
      begin
        applyStimulus(8'h10, 8'hF0, 2'd3, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, fc);
        applyStimulus(8'hFF, 8'h00, 2'd0, 1'b1, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, fc);
        applyStimulus(8'h7F, 8'h81, 2'd0, 1'b1, 8'h01, 2'd2, 1'b0, 1'b0, 1'b0, fc);
        applyStimulus(8'h80, 8'h7F, 2'd0, 1'b1, 8'h00, 2'd3, 1'b1, 1'b1, 1'b0, fc);
      end
      begin
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join

    $display("[TB] back-to-back operations");
    applyStimulus(8'h00, 8'h01, 2'd0, 1'b1, 8'hFF, 2'd0, 1'b1, 1'b1, 1'b0, c1);
    applyStimulus(8'h01, 8'h01, 2'd0, 1'b0, 8'h02, 2'd0, 1'b1, 1'b0, 1'b0, c2);
    checkOutput("noBubble", 32'(c2 - c1), 32'd1);

    for (int useRst = 0; useRst < 2; useRst++) begin
      $display("[TB] abort using %s", useRst ? "rst" : "clear");
      applyStimulus(8'hFF, 8'h01, 2'd3, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, fc);
      applyStimulus(8'hFF, 8'h01, 2'd3, 1'b0, 8'h01, 2'd1, 1'b0, 1'b0, 1'b0, fc);
      abortOp(useRst[0]);
      applyStimulus(8'h01, 8'h01, 2'd1, 1'b0, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0, fc);
      applyStimulus(8'h00, 8'h00, 2'd1, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, fc);
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iddmm_addsub_serial.md
IDDMM_ADDSUB_SERIAL -- requirements
Module: iddmm_addsub_serial

Interface
REQ-001 The block SHALL have parameter K, default 256, giving the word width in bits.
REQ-002 The block SHALL have parameter N, default 16, giving the maximum number of words per operand.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(N), giving the word-index width.
REQ-004 The block SHALL provide the following ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort of the operation in progress.
- cfg_words  in  ADDR_W  operand length minus 1; sampled on the first word.
- cfg_sub  in  1  mode: 1 = subtract (a-b), 0 = add (a+b); sampled on the first word.
- in_valid  in  1  word pair presented.
- in_ready  out  1  block accepts a word this cycle.
- in_a  in  K  operand A word, least-significant word first.
- in_b  in  K  operand B word, least-significant word first.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts a result word.
- out_data  out  K  result word.
- out_addr  out  ADDR_W  index of the result word.
- out_last  out  1  result word is the final word of the operand.
- out_flag  out  1  final carry (add) or final borrow (sub); meaningful only when out_last=1.
- out_zero  out  1  entire multi-word result is zero; meaningful only when out_last=1.

Function
REQ-005 An accepted word ("fire") SHALL occur when in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL equal (!out_valid || out_ready) && !clear.
REQ-007 The FSM SHALL have two states: IDLE (expecting word 0) and BUSY (expecting word 1..len).
REQ-008 A fire in IDLE SHALL latch len=cfg_words and mode=cfg_sub, set the word counter to 0, and use a carry/borrow input of 0.
REQ-009 If len=0, a fire in IDLE SHALL leave the FSM in IDLE; otherwise the FSM SHALL go to BUSY.
REQ-010 A fire in BUSY SHALL use the latched len and mode and ignore cfg_words and cfg_sub.
REQ-011 In add mode, out_data SHALL be the low K bits of a+b+c_in, and c_out SHALL be bit K of that sum.
REQ-012 In sub mode, out_data SHALL be the low K bits of a-b-bw_in, and bw_out SHALL be 1 exactly when a < b+bw_in (unsigned).
REQ-013 The carry/borrow register SHALL be (K+1)-bit exact and SHALL update only on a fire.
REQ-014 Each fire SHALL load the output register one cycle later, fixing latency at 1 cycle, with out_addr equal to the counter value and out_last=(counter==len).
REQ-015 A fire with counter==len SHALL return the FSM to IDLE and reset the carry/borrow register to 0.
REQ-016 On the last word, out_flag SHALL be the final c_out or bw_out.
REQ-017 On the last word, out_zero SHALL be 1 exactly when all result words of the operation were zero, using a running AND that is reset on word 0.
REQ-018 The output register SHALL hold its contents stable while out_valid=1 and out_ready=0.
REQ-019 out_valid SHALL clear after an out_ready handshake unless a new fire occurs in the same cycle.
REQ-020 A fire on the last word and a fire on word 0 of the next operation in back-to-back cycles SHALL both be accepted, giving full throughput of 1 word/cycle with no bubble.
REQ-021 clear=1 SHALL force the FSM to IDLE, zero the counter and carry/borrow register, drop out_valid, and accept no word that cycle; clear overrides a simultaneous in_valid.
REQ-022 When cfg_words > N-1, the block SHALL saturate len to N-1.
REQ-023 Counter wrap is impossible; the counter SHALL never exceed len.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL load state IDLE and counter=0, and set carry/borrow, out_valid, out_data, out_addr, out_last, out_flag and out_zero to 0, with in_ready low.
REQ-025 On the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-026 rst SHALL take priority over clear and over in_valid.
REQ-027 rst asserted mid-operation SHALL discard the partial result, so the next fire is treated as word 0.

Verification (K=8, N=4)
REQ-028 Scenario add with carry chain: cfg_sub=0, cfg_words=1, a={0x01,0xFF} and b={0x00,0x01} (MSW first). Required response: out words 0x00 then 0x02, out_flag=0, out_zero=0, and each word appears 1 cycle after its fire.
REQ-029 Scenario subtract with borrow out: cfg_sub=1, cfg_words=1, a={0x00,0x00} and b={0x00,0x01}. Required response: words 0xFF, 0xFF; out_flag=1; out_zero=0.
REQ-030 Scenario equal operands: cfg_sub=1, cfg_words=3, a=b=0x12345678. Required response: 4 words 0x00, out_addr 0..3, out_last only on addr 3, out_flag=0, out_zero=1.
REQ-031 Scenario backpressure: out_ready=0 for 3 cycles during a 4-word add. Required response: in_ready=0 while out_valid=1 and out_ready=0; out_data stable; no word lost or duplicated; the final result is the same as with out_ready=1 throughout.
REQ-032 Scenario back-to-back operations: a 1-word sub 0x00-0x01 (flag=1), immediately followed by a 1-word add 0x01+0x01. Required response: the second result is 0x02 with out_flag=0 (borrow not leaked), and there is no idle cycle between the operations.
REQ-033 Scenario abort: assert clear at word 2 of a 4-word operation, then start a new 2-word add. Required response: out_valid drops the next cycle; the new operation starts at out_addr=0 with carry-in 0. Repeat the scenario using rst instead of clear; the required response is identical.
